// File: rtl/dma_block_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : dma_block_engine_if
//  Description : Port bundle between the block-transfer engine and its
//                surroundings: request/status handshake toward the control
//                unit and the data-memory port driven by the engine.
//                master = engine side, slave = control unit / memory side.
//                Optional checksum output exists only when DMA_CHECKSUM_EN
//                is defined.
//  Signals     : start, op, srcAddy, dstAddy, length, fillData  (request)
//                busy, done, error, wordCount                    (status)
//                memoryAddy, writeData, cu_writeEnable,
//                cu_readEnable, dataRAMOutput                    (memory)
//                checksum                        (DMA_CHECKSUM_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dma_block_engine_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              start;
    logic              op;
    logic [ADDR_W-1:0] srcAddy;
    logic [ADDR_W-1:0] dstAddy;
    logic [ADDR_W:0]   length;
    logic [DATA_W-1:0] fillData;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   wordCount;
    logic [ADDR_W-1:0] memoryAddy;
    logic [DATA_W-1:0] writeData;
    logic              cu_writeEnable;
    logic              cu_readEnable;
    logic [DATA_W-1:0] dataRAMOutput;
`ifdef DMA_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    modport master (
`ifdef DMA_CHECKSUM_EN
        output checksum,
`endif
        input  start, op, srcAddy, dstAddy, length, fillData, dataRAMOutput,
        output busy, done, error, wordCount,
        output memoryAddy, writeData, cu_writeEnable, cu_readEnable
    );

    modport slave (
`ifdef DMA_CHECKSUM_EN
        input  checksum,
`endif
        output start, op, srcAddy, dstAddy, length, fillData, dataRAMOutput,
        input  busy, done, error, wordCount,
        input  memoryAddy, writeData, cu_writeEnable, cu_readEnable
    );
endinterface
`default_nettype wire

// File: rtl/dma_block_engine.sv
`default_nettype none
// ============================================================================
//  Module      : dma_block_engine
//  Description : Block-transfer engine owning the data-memory port while
//                busy. COPY reads src+i then writes dst+i (two cycles per
//                word, ascending addresses); FILL writes a constant to dst+i
//                (one cycle per word). Requests whose range would run past
//                the end of memory are rejected with a done+error pulse.
//                Every output is registered.
//  Ports       : clock, reset (sync, active high)
//                bus : dma_block_engine_if.master (request, status, memory)
//  Option      : DMA_CHECKSUM_EN adds bus.checksum, the modulo-2^DATA_W sum
//                of every word written by the current transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_block_engine #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  wire logic            clock,
    input  wire logic            reset,
    dma_block_engine_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        FILLW = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Number of words in memory, in the widened range-check width
    localparam logic [ADDR_W+1:0] MEM_WORDS = {2'b01, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [ADDR_W:0]   idx_q, idx_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
`ifdef DMA_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

    logic [ADDR_W+1:0] w_src_end;
    logic [ADDR_W+1:0] w_dst_end;
    logic              w_range_bad;
    logic [ADDR_W:0]   w_idx_inc;
    logic              w_more;

    // Widened by two bits so base + length can never wrap
    assign w_src_end   = {2'b00, bus.srcAddy} + {1'b0, bus.length};
    assign w_dst_end   = {2'b00, bus.dstAddy} + {1'b0, bus.length};
    assign w_range_bad = (w_dst_end > MEM_WORDS) ||
                         (!bus.op && (w_src_end > MEM_WORDS));

    assign w_idx_inc   = idx_q + (ADDR_W+1)'(1);
    assign w_more      = (w_idx_inc < len_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            fill_q       <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
            mem_addr_q   <= '0;
            write_data_q <= '0;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
`ifdef DMA_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            fill_q       <= fill_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            word_count_q <= word_count_d;
            mem_addr_q   <= mem_addr_d;
            write_data_q <= write_data_d;
            we_q         <= we_d;
            re_q         <= re_d;
`ifdef DMA_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    // Outputs are registered, so each branch computes the output values the
    // engine presents in the state it is about to enter.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        fill_d       = fill_q;
        idx_d        = idx_q;
        word_count_d = word_count_q;
        mem_addr_d   = mem_addr_q;
        write_data_d = write_data_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        we_d         = 1'b0;
        re_d         = 1'b0;
`ifdef DMA_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d        = bus.srcAddy;
                    dst_d        = bus.dstAddy;
                    len_d        = bus.length;
                    fill_d       = bus.fillData;
                    idx_d        = '0;
                    word_count_d = '0;
`ifdef DMA_CHECKSUM_EN
                    checksum_d   = '0;
`endif
                    if (bus.length == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else if (w_range_bad) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else if (!bus.op) begin
                        state_d    = READ;
                        busy_d     = 1'b1;
                        re_d       = 1'b1;
                        mem_addr_d = bus.srcAddy;
                    end else begin
                        state_d      = FILLW;
                        busy_d       = 1'b1;
                        we_d         = 1'b1;
                        mem_addr_d   = bus.dstAddy;
                        write_data_d = bus.fillData;
                    end
                end
            end

            READ: begin
                // Read data is valid at the edge closing the read cycle
                state_d      = WRITE;
                busy_d       = 1'b1;
                we_d         = 1'b1;
                write_data_d = bus.dataRAMOutput;
                mem_addr_d   = dst_q + idx_q[ADDR_W-1:0];
            end

            WRITE: begin
                word_count_d = word_count_q + (ADDR_W+1)'(1);
                idx_d        = w_idx_inc;
`ifdef DMA_CHECKSUM_EN
                checksum_d   = checksum_q + write_data_q;
`endif
                if (w_more) begin
                    state_d    = READ;
                    busy_d     = 1'b1;
                    re_d       = 1'b1;
                    mem_addr_d = src_q + w_idx_inc[ADDR_W-1:0];
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end

            FILLW: begin
                word_count_d = word_count_q + (ADDR_W+1)'(1);
                idx_d        = w_idx_inc;
`ifdef DMA_CHECKSUM_EN
                checksum_d   = checksum_q + write_data_q;
`endif
                if (w_more) begin
                    state_d      = FILLW;
                    busy_d       = 1'b1;
                    we_d         = 1'b1;
                    write_data_d = fill_q;
                    mem_addr_d   = dst_q + w_idx_inc[ADDR_W-1:0];
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end

            FIN: begin
                // done/error were raised on entry; start is ignored here
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.error          = error_q;
    assign bus.wordCount      = word_count_q;
    assign bus.memoryAddy     = mem_addr_q;
    assign bus.writeData      = write_data_q;
    assign bus.cu_writeEnable = we_q;
    assign bus.cu_readEnable  = re_q;
`ifdef DMA_CHECKSUM_EN
    assign bus.checksum       = checksum_q;
`endif

endmodule
`default_nettype wire
